// File: rtl/hazard_stall_ctrl.sv
// Hazard and sequencing controller for the five-stage MIPS pipeline.
// Stalls the instruction in D on RAW hazards (Tuse/Tnew) or while the
// multiply/divide unit is busy. Also tracks MDU occupancy and counts stall cycles.
module hazard_stall_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  D_rs,
    input  logic [4:0]  D_rt,
    input  logic [1:0]  D_rs_tuse,
    input  logic [1:0]  D_rt_tuse,
    input  logic        D_is_md,
    input  logic [4:0]  E_A3,
    input  logic [1:0]  E_tnew,
    input  logic [4:0]  M_A3,
    input  logic [1:0]  M_tnew,
    input  logic        E_start,
    input  logic        E_is_div,
    output logic        stall,
    output logic        PC_en,
    output logic        D_en,
    output logic        E_flush,
    output logic        md_busy,
    output logic        md_done,
    output logic [31:0] stall_count
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      stall_count_q, stall_count_d;

    // Source operands of the D instruction, index 0 = rs, 1 = rt.
    logic [1:0][4:0] src_reg;
    logic [1:0][1:0] src_tuse;
    logic [1:0]      src_stall;
    logic            md_stall;

    assign src_reg  = {D_rt, D_rs};
    assign src_tuse = {D_rt_tuse, D_rs_tuse};

    // Per-operand RAW check: a producer still ahead of the consumer's need stalls D.
    // Register 0 is never a real dependency, so it is filtered up front.
    // A Tuse of 3 can never be exceeded by a Tnew of at most 2.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            always_comb begin
                src_stall[gi] = (src_reg[gi] != 5'd0) &&
                                (((src_reg[gi] == E_A3) && (E_tnew > src_tuse[gi])) ||
                                 ((src_reg[gi] == M_A3) && (M_tnew > src_tuse[gi])));
            end
        end
    endgenerate

    // MDU occupancy: a start already in E counts as busy in the same cycle.
    assign md_busy  = (cnt_q != '0);
    assign md_done  = (cnt_q == CNT_W'(1)) && !E_start;
    assign md_stall = D_is_md && (md_busy || E_start);

    assign stall       = |src_stall || md_stall;
    assign PC_en       = !stall;
    assign D_en        = !stall;
    assign E_flush     = stall;
    assign stall_count = stall_count_q;

    // Next-state: a new start always reloads the counter, even mid-operation.
    always_comb begin
        cnt_d = cnt_q;
        if (E_start) begin
            cnt_d = E_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
        stall_count_d = stall_count_q + {31'd0, stall};
    end

    // State registers; reset abandons any in-flight MDU operation without a done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q         <= '0;
            stall_count_q <= '0;
        end else begin
            cnt_q         <= cnt_d;
            stall_count_q <= stall_count_d;
        end
    end

endmodule
